r2sdf_bitrev_reorder: RTL

Streaming bit-reversal reorder buffer at the output of the radix-2 SDF FFT pipeline. The last R2SDF stage emits bins in bit-reversed order, one complex sample per cycle. This block collects each 2^N-point frame into one half of a ping-pong buffer, then streams it out in natural bin order. The other half accepts the next frame at the same time.

---
 rtl/r2sdf_bitrev_reorder_if.sv | 35 +++
 rtl/r2sdf_bitrev_reorder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/r2sdf_bitrev_reorder_if.sv
// ============================================================================
// Module   : r2sdf_bitrev_reorder_if
// Brief    : Sample stream bundle for the R2SDF bit-reversal reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface r2sdf_bitrev_reorder_if #(
    parameter int N  = 3,
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_sop;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_sop;
    logic [N-1:0]  out_idx;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          frame_drop;

    // Source of bit-reversed samples and consumer of natural-order samples.
    modport master (
        output in_valid, in_sop, in_re, in_im,
        input  out_valid, out_sop, out_idx, out_re, out_im, frame_drop
    );

    modport slave (
        input  in_valid, in_sop, in_re, in_im,
        output out_valid, out_sop, out_idx, out_re, out_im, frame_drop
    );
endinterface

`default_nettype wire

// File: rtl/r2sdf_bitrev_reorder.sv
// ============================================================================
// Module   : r2sdf_bitrev_reorder
// Brief    : Ping-pong buffer turning bit-reversed FFT bins into natural order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module r2sdf_bitrev_reorder #(
    parameter int N  = 3,
    parameter int DW = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    r2sdf_bitrev_reorder_if.slave  bus
);

    localparam int          c_DEPTH   = 1 << N;
    localparam logic [N-1:0] c_CNT_MAX = {N{1'b1}};
    localparam logic [N-1:0] c_CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    // Both banks live in one array; the MSB of the address selects the bank.
    logic [2*DW-1:0] r_mem [0:2*c_DEPTH-1];

    logic            r_wr_bank;
    logic            r_rd_bank;
    logic [N-1:0]    r_wr_cnt;
    logic [N-1:0]    r_rd_cnt;
    logic            r_rd_active;

    logic            r_out_valid;
    logic            r_out_sop;
    logic [N-1:0]    r_out_idx;
    logic [DW-1:0]   r_out_re;
    logic [DW-1:0]   r_out_im;
    logic            r_frame_drop;

    logic [N-1:0]    w_a;
    logic [N-1:0]    w_wr_addr;
    logic            w_wr_en;
    logic            w_frame_done;
    logic            w_drop;
    logic [2*DW-1:0] w_rd_data;

    // ------------------------------------------------------------------------
    // Write-side address: in_sop forces arrival index 0 to resynchronise.
    // ------------------------------------------------------------------------
    always_comb begin
        w_a          = bus.in_sop ? '0 : r_wr_cnt;
        w_wr_en      = bus.in_valid;
        w_frame_done = bus.in_valid && (w_a == c_CNT_MAX);
        w_drop       = bus.in_valid && bus.in_sop && (r_wr_cnt != '0);
    end

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_rev
            assign w_wr_addr[k] = w_a[N-1-k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wr_bank, w_wr_addr}] <= {bus.in_re, bus.in_im};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt     <= '0;
            r_wr_bank    <= 1'b0;
            r_frame_drop <= 1'b0;
        end else begin
            r_frame_drop <= w_drop;
            if (w_wr_en) begin
                r_wr_cnt <= w_a + c_CNT_ONE;
            end
            if (w_frame_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read side. A completing frame restarts readout even when the previous
    // bank issues its final address on the same edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_rd_active <= 1'b0;
        end else if (w_frame_done) begin
            r_rd_bank   <= r_wr_bank;
            r_rd_cnt    <= '0;
            r_rd_active <= 1'b1;
        end else if (r_rd_active) begin
            r_rd_cnt <= r_rd_cnt + c_CNT_ONE;
            if (r_rd_cnt == c_CNT_MAX) begin
                r_rd_active <= 1'b0;
            end
        end
    end

    assign w_rd_data = r_mem[{r_rd_bank, r_rd_cnt}];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_idx   <= '0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            r_out_valid <= r_rd_active;
            r_out_sop   <= r_rd_active && (r_rd_cnt == '0);
            if (r_rd_active) begin
                r_out_idx <= r_rd_cnt;
                r_out_re  <= w_rd_data[2*DW-1:DW];
                r_out_im  <= w_rd_data[DW-1:0];
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_sop    = r_out_sop;
    assign bus.out_idx    = r_out_idx;
    assign bus.out_re     = r_out_re;
    assign bus.out_im     = r_out_im;
    assign bus.frame_drop = r_frame_drop;

endmodule

`default_nettype wire
